// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event collector: sticky per-channel rise/fall flags, served
// one event at a time to a single valid/ready consumer by a round-robin arbiter.
module edge_event_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] signal_in,
    input  logic              evt_ready,
    input  logic              overrun_clr,
    output logic              evt_valid,
    output logic [CH_W-1:0]   evt_ch,
    output logic              evt_is_rise,
    output logic              evt_is_fall,
    output logic [NUM_CH-1:0] overrun
);

    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] pendR_q, pendR_d;
    logic [NUM_CH-1:0] pendF_q, pendF_d;
    logic [NUM_CH-1:0] overrun_q, overrun_d;
    logic [CH_W-1:0]   rrPtr_q, rrPtr_d;
    logic              evtValid_q, evtValid_d;
    logic [CH_W-1:0]   evtCh_q, evtCh_d;
    logic              evtIsRise_q, evtIsRise_d;
    logic              evtIsFall_q, evtIsFall_d;

    logic [NUM_CH-1:0] rise, fall, anyPend, grantMask;
    logic              slotFree, found, grant;
    logic [CH_W-1:0]   grantCh, candCh;
    int                searchIdx;

    always_comb begin
        rise      = signal_in & ~prev_q;
        fall      = ~signal_in & prev_q;
        anyPend   = pendR_q | pendF_q;
        slotFree  = ~evtValid_q | evt_ready;
        found     = 1'b0;
        grantCh   = '0;
        candCh    = '0;
        searchIdx = 0;

        // Scan starting at the round-robin pointer; the first pending channel wins.
        for (int k = 0; k < NUM_CH; k++) begin
            searchIdx = (int'(rrPtr_q) + k) % NUM_CH;
            candCh    = CH_W'(searchIdx);
            if (!found && anyPend[candCh]) begin
                found   = 1'b1;
                grantCh = candCh;
            end
        end

        grant     = slotFree & found;
        grantMask = grant ? (NUM_CH'(1) << grantCh) : '0;

        // A new edge arriving on the granted channel re-arms its flag (set beats clear).
        pendR_d = (pendR_q & ~grantMask) | rise;
        pendF_d = (pendF_q & ~grantMask) | fall;

        overrun_d = (overrun_q & ~{NUM_CH{overrun_clr}})
                  | (((rise & pendR_q) | (fall & pendF_q)) & ~grantMask);

        rrPtr_d     = rrPtr_q;
        evtValid_d  = evtValid_q;
        evtCh_d     = evtCh_q;
        evtIsRise_d = evtIsRise_q;
        evtIsFall_d = evtIsFall_q;
        if (grant) begin
            evtValid_d  = 1'b1;
            evtCh_d     = grantCh;
            evtIsRise_d = pendR_q[grantCh];
            evtIsFall_d = pendF_q[grantCh];
            rrPtr_d     = (grantCh == CH_W'(NUM_CH - 1)) ? '0 : grantCh + CH_W'(1);
        end else if (slotFree) begin
            evtValid_d = 1'b0;
        end
    end

    // prev_q tracks the inputs even in reset so release produces no phantom edge.
    always_ff @(posedge clk) begin
        prev_q <= signal_in;
        if (reset) begin
            pendR_q     <= '0;
            pendF_q     <= '0;
            overrun_q   <= '0;
            rrPtr_q     <= '0;
            evtValid_q  <= 1'b0;
            evtCh_q     <= '0;
            evtIsRise_q <= 1'b0;
            evtIsFall_q <= 1'b0;
        end else begin
            pendR_q     <= pendR_d;
            pendF_q     <= pendF_d;
            overrun_q   <= overrun_d;
            rrPtr_q     <= rrPtr_d;
            evtValid_q  <= evtValid_d;
            evtCh_q     <= evtCh_d;
            evtIsRise_q <= evtIsRise_d;
            evtIsFall_q <= evtIsFall_d;
        end
    end

    assign evt_valid   = evtValid_q;
    assign evt_ch      = evtCh_q;
    assign evt_is_rise = evtIsRise_q;
    assign evt_is_fall = evtIsFall_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: reset, latency, round-robin order,
// stall/merge, overrun set/clear and reset during activity.
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] signal_in;
    logic       evt_ready;
    logic       overrun_clr;
    logic       evt_valid;
    logic [1:0] evt_ch;
    logic       evt_is_rise;
    logic       evt_is_fall;
    logic [3:0] overrun;

    int passCount = 0;
    int totalCount = 0;

    edge_event_arbiter #(.NUM_CH(4), .CH_W(2)) dut (
        .clk(clk),
        .reset(reset),
        .signal_in(signal_in),
        .evt_ready(evt_ready),
        .overrun_clr(overrun_clr),
        .evt_valid(evt_valid),
        .evt_ch(evt_ch),
        .evt_is_rise(evt_is_rise),
        .evt_is_fall(evt_is_fall),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Advance past one rising edge; outputs are sampled and inputs driven 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input logic [3:0] level);
        reset       = 1'b1;
        signal_in   = level;
        evt_ready   = 1'b1;
        overrun_clr = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        doReset(4'b1111);
        totalCount++;
        if ({evt_valid, evt_ch, evt_is_rise, evt_is_fall, overrun} !== 9'b0)
            $display("[TB] FAIL reset_state got %b exp %b",
                     {evt_valid, evt_ch, evt_is_rise, evt_is_fall, overrun}, 9'b0);
        else passCount++;
        for (int i = 0; i < 10; i++) begin
            tick();
            totalCount++;
            if ({evt_valid, overrun} !== 5'b0)
                $display("[TB] FAIL reset_quiet cycle %0d got %b exp %b", i, {evt_valid, overrun}, 5'b0);
            else passCount++;
        end
    endtask

    task automatic test_latency();
        doReset(4'b0000);
        signal_in = 4'b0100;
        tick();
        totalCount++;
        if (evt_valid !== 1'b0)
            $display("[TB] FAIL latency_early got %b exp 0", evt_valid);
        else passCount++;
        tick();
        totalCount++;
        if ({evt_valid, evt_ch, evt_is_rise, evt_is_fall} !== 5'b1_10_1_0)
            $display("[TB] FAIL latency_event got %b exp %b",
                     {evt_valid, evt_ch, evt_is_rise, evt_is_fall}, 5'b1_10_1_0);
        else passCount++;
        tick();
        totalCount++;
        if (evt_valid !== 1'b0)
            $display("[TB] FAIL latency_pop got %b exp 0", evt_valid);
        else passCount++;
    endtask

    task automatic test_round_robin();
        // Each row: signal_in to drive, then expected {valid, ch, rise, fall} after the edge.
        logic [3:0] sigTab [15];
        logic [4:0] expTab [15];
        sigTab = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
                   4'b1100, 4'b1100, 4'b1100,
                   4'b0000, 4'b0000, 4'b0000,
                   4'b0011, 4'b0011, 4'b0011, 4'b0011};
        expTab = '{5'b0_00_0_0, 5'b1_00_1_0, 5'b1_01_1_0, 5'b1_10_1_0, 5'b1_11_1_0,
                   5'b0_00_0_0, 5'b1_00_0_1, 5'b1_01_0_1,
                   5'b0_00_0_0, 5'b1_10_0_1, 5'b1_11_0_1,
                   5'b0_00_0_0, 5'b1_00_1_0, 5'b1_01_1_0, 5'b0_00_0_0};
        doReset(4'b0000);
        for (int i = 0; i < 15; i++) begin
            signal_in = sigTab[i];
            tick();
            totalCount++;
            if (expTab[i][4] == 1'b0) begin
                if (evt_valid !== 1'b0)
                    $display("[TB] FAIL rr_step%0d got valid=%b exp 0", i, evt_valid);
                else passCount++;
            end else if ({evt_valid, evt_ch, evt_is_rise, evt_is_fall} !== expTab[i]) begin
                $display("[TB] FAIL rr_step%0d got %b exp %b", i,
                         {evt_valid, evt_ch, evt_is_rise, evt_is_fall}, expTab[i]);
            end else passCount++;
        end
    endtask

    task automatic test_stall_merge();
        doReset(4'b0000);
        evt_ready = 1'b0;
        signal_in = 4'b0010;
        tick();
        tick();
        totalCount++;
        if ({evt_valid, evt_ch, evt_is_rise, evt_is_fall} !== 5'b1_01_1_0)
            $display("[TB] FAIL stall_grant got %b exp %b",
                     {evt_valid, evt_ch, evt_is_rise, evt_is_fall}, 5'b1_01_1_0);
        else passCount++;
        signal_in = 4'b0000;
        tick();
        signal_in = 4'b0010;
        tick();
        totalCount++;
        if ({evt_valid, evt_ch, evt_is_rise, evt_is_fall, overrun} !== 9'b1_01_1_0_0000)
            $display("[TB] FAIL stall_hold got %b exp %b",
                     {evt_valid, evt_ch, evt_is_rise, evt_is_fall, overrun}, 9'b1_01_1_0_0000);
        else passCount++;
        signal_in = 4'b0000;
        tick();
        totalCount++;
        if ({evt_valid, evt_ch, evt_is_rise, evt_is_fall, overrun} !== 9'b1_01_1_0_0010)
            $display("[TB] FAIL stall_overrun got %b exp %b",
                     {evt_valid, evt_ch, evt_is_rise, evt_is_fall, overrun}, 9'b1_01_1_0_0010);
        else passCount++;
        evt_ready = 1'b1;
        tick();
        totalCount++;
        if ({evt_valid, evt_ch, evt_is_rise, evt_is_fall} !== 5'b1_01_1_1)
            $display("[TB] FAIL stall_merged got %b exp %b",
                     {evt_valid, evt_ch, evt_is_rise, evt_is_fall}, 5'b1_01_1_1);
        else passCount++;
        tick();
        totalCount++;
        if ({evt_valid, overrun} !== 5'b0_0010)
            $display("[TB] FAIL stall_drain got %b exp %b", {evt_valid, overrun}, 5'b0_0010);
        else passCount++;
    endtask

    task automatic test_overrun_clr();
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        totalCount++;
        if (overrun !== 4'b0000)
            $display("[TB] FAIL clr_plain got %b exp 0000", overrun);
        else passCount++;
        evt_ready = 1'b0;
        signal_in = 4'b0001;
        tick();
        tick();
        signal_in = 4'b0000;
        tick();
        signal_in = 4'b0001;
        tick();
        signal_in = 4'b0000;
        tick();
        totalCount++;
        if (overrun !== 4'b0001)
            $display("[TB] FAIL clr_setup got %b exp 0001", overrun);
        else passCount++;
        signal_in   = 4'b0001;
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        totalCount++;
        if (overrun !== 4'b0001)
            $display("[TB] FAIL clr_set_wins got %b exp 0001", overrun);
        else passCount++;
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        totalCount++;
        if (overrun !== 4'b0000)
            $display("[TB] FAIL clr_again got %b exp 0000", overrun);
        else passCount++;
    endtask

    task automatic test_reset_midop();
        signal_in = 4'b1001;
        tick();
        totalCount++;
        if ({evt_valid, evt_ch} !== 3'b1_00)
            $display("[TB] FAIL midop_held got %b exp %b", {evt_valid, evt_ch}, 3'b1_00);
        else passCount++;
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        evt_ready = 1'b1;
        totalCount++;
        if ({evt_valid, overrun} !== 5'b0)
            $display("[TB] FAIL midop_reset got %b exp %b", {evt_valid, overrun}, 5'b0);
        else passCount++;
        for (int i = 0; i < 4; i++) begin
            tick();
            totalCount++;
            if (evt_valid !== 1'b0)
                $display("[TB] FAIL midop_no_event cycle %0d got %b exp 0", i, evt_valid);
            else passCount++;
        end
    endtask

    initial begin
        reset       = 1'b1;
        signal_in   = 4'b0000;
        evt_ready   = 1'b1;
        overrun_clr = 1'b0;
        test_reset();
        test_latency();
        test_round_robin();
        test_stall_merge();
        test_overrun_clr();
        test_reset_midop();
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
